multi_level_counter: RTL and testbench

- Multi-channel successor to the single-channel level counter.
- Each of N_CH level inputs is synchronised and counted on a shared slow tick while the input is high.
- Each channel has its own mode: hold, wrap, saturate-up or count-down. Each channel also gets a threshold flag and a sticky overflow flag.
- The slow rate comes from a clock-enable tick, not a derived clock, so the whole block runs in the CLK100MHZ domain.

---
 rtl/multi_level_counter.sv | 64 ++++++
 tb/tb_multi_level_counter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/multi_level_counter.sv
// multi_level_counter: per-channel synchronised level counters on a shared prescaler tick, with hold/wrap/saturate/count-down modes, threshold compare and sticky overflow
module multi_level_counter #(
  parameter int N_CH     = 4,
  parameter int COUNT_W  = 8,
  parameter int TICK_MAX = 33000000
) (
  input  logic                      CLK100MHZ,
  input  logic                      reset,
  input  logic [N_CH-1:0]           clear,
  input  logic [N_CH-1:0]           lv_in,
  input  logic [2*N_CH-1:0]         mode,
  input  logic [COUNT_W-1:0]        threshold,
  output logic [N_CH*COUNT_W-1:0]   hold_count,
  output logic [N_CH-1:0]           at_threshold,
  output logic [N_CH-1:0]           ovf,
  output logic                      tick
);
  localparam int PW = TICK_MAX > 1 ? $clog2(TICK_MAX) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_MAX - 1);
  logic [PW-1:0] pre, pre_nxt;
  logic [N_CH-1:0] lv_m, lv_s;
  always_comb pre_nxt = pre == PMAX ? '0 : pre + 1'b1;
  always_ff @(posedge CLK100MHZ or negedge reset)
    if (!reset) begin
      pre  <= '0;
      tick <= 1'b0;
      lv_m <= '0;
      lv_s <= '0;
    end else begin
      pre  <= pre_nxt;
      tick <= pre_nxt == PMAX;
      lv_m <= lv_in;
      lv_s <= lv_m;
    end
  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_ch
      logic [COUNT_W-1:0] cnt, nxt;
      logic [1:0] m;
      logic hit, o;
      always_comb begin
        m   = mode[2*g +: 2];
        nxt = m == 2'b01 ? cnt + 1'b1 :
              m == 2'b10 && !(&cnt) ? cnt + 1'b1 :
              m == 2'b11 && |cnt ? cnt - 1'b1 : cnt;
        hit = m == 2'b11 ? ~|cnt : (m[0] ^ m[1]) ? &cnt : 1'b0;
      end
      always_ff @(posedge CLK100MHZ or negedge reset)
        if (!reset) begin
          cnt <= '0;
          o   <= 1'b0;
        end else if (clear[g]) begin
          cnt <= '0;
          o   <= 1'b0;
        end else if (tick && lv_s[g]) begin
          cnt <= nxt;
          o   <= o | hit;
        end
      assign hold_count[COUNT_W*g +: COUNT_W] = cnt;
      assign at_threshold[g] = cnt >= threshold;
      assign ovf[g] = o;
    end
  endgenerate
endmodule

// File: tb/tb_multi_level_counter.sv
// tb_multi_level_counter: randomized and directed checks of multi_level_counter against a behavioural model
module tb_multi_level_counter;
  logic clk = 1'b0, reset = 1'b0;
  logic [1:0] clear = '0, lv_in = '0;
  logic [3:0] mode = '0, threshold = '0;
  logic [7:0] hold_count;
  logic [1:0] at_threshold, ovf;
  logic tick;
  logic [12:0] st;
  int n_chk = 0, n_fail = 0;
  int e = 0;
  int cnt_m[2];
  bit ovf_m[2], h1[2], h2[2];
  always #5 clk = ~clk;
  multi_level_counter #(.N_CH(2), .COUNT_W(4), .TICK_MAX(4)) dut (
    .CLK100MHZ(clk), .reset(reset), .clear(clear), .lv_in(lv_in), .mode(mode),
    .threshold(threshold), .hold_count(hold_count), .at_threshold(at_threshold),
    .ovf(ovf), .tick(tick)
  );
  assign st = {tick, ovf, at_threshold, hold_count};
  function automatic logic [12:0] exp_st();
    logic [3:0] c0, c1;
    c0 = 4'(cnt_m[0]);
    c1 = 4'(cnt_m[1]);
    return {reset && (e % 4 == 3), ovf_m[1], ovf_m[0], c1 >= threshold, c0 >= threshold, c1, c0};
  endfunction
  task automatic model_reset();
    e = 0;
    for (int i = 0; i < 2; i++) begin
      cnt_m[i] = 0; ovf_m[i] = 0; h1[i] = 0; h2[i] = 0;
    end
  endtask
  task automatic cyc();
    bit tk, lvs;
    @(posedge clk);
    if (reset) begin
      tk = e % 4 == 3;
      for (int i = 0; i < 2; i++) begin
        lvs = h2[i];
        h2[i] = h1[i];
        h1[i] = lv_in[i];
        if (clear[i]) begin
          cnt_m[i] = 0; ovf_m[i] = 0;
        end else if (tk && lvs) begin
          case (mode[2*i +: 2])
            2'd1: begin if (cnt_m[i] == 15) ovf_m[i] = 1; cnt_m[i] = (cnt_m[i] + 1) % 16; end
            2'd2: if (cnt_m[i] == 15) ovf_m[i] = 1; else cnt_m[i]++;
            2'd3: if (cnt_m[i] == 0) ovf_m[i] = 1; else cnt_m[i]--;
            default: ;
          endcase
        end
      end
      e++;
    end
    @(negedge clk);
  endtask
  task automatic test_reset();
    model_reset();
    threshold = 4'd0;
    #1;
    n_chk++;
    if (st !== 13'b0_00_11_00000000) begin n_fail++; $display("FAIL reset_thr0 got %b exp %b", st, 13'b0_00_11_00000000); end
    threshold = 4'd5;
    #1;
    n_chk++;
    if (st !== 13'b0_00_00_00000000) begin n_fail++; $display("FAIL reset_thr5 got %b exp %b", st, 13'b0_00_00_00000000); end
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic test_idle();
    int nt = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      nt += tick;
      n_chk++;
      if (st !== exp_st()) begin n_fail++; $display("FAIL idle cyc %0d got %b exp %b", k, st, exp_st()); end
    end
    n_chk++;
    if (nt !== 5) begin n_fail++; $display("FAIL idle_tick_count got %0d exp 5", nt); end
  endtask
  task automatic test_wrap();
    mode = 4'b0001;
    lv_in = 2'b01;
    for (int k = 0; k < 68; k++) begin
      cyc();
      n_chk++;
      if (st !== exp_st()) begin n_fail++; $display("FAIL wrap cyc %0d got %b exp %b", k, st, exp_st()); end
    end
    n_chk++;
    if ({ovf, hold_count} !== 10'b00_1_0000_0001) begin n_fail++; $display("FAIL wrap_final got %b exp %b", {ovf, hold_count}, 10'b00_1_0000_0001); end
  endtask
  task automatic test_sat();
    mode = 4'b1000;
    lv_in = 2'b11;
    threshold = 4'd10;
    for (int k = 0; k < 80; k++) begin
      cyc();
      n_chk++;
      if (st !== exp_st()) begin n_fail++; $display("FAIL sat cyc %0d got %b exp %b", k, st, exp_st()); end
    end
    n_chk++;
    if ({at_threshold[1], ovf[1], hold_count[7:4]} !== 6'b11_1111) begin n_fail++; $display("FAIL sat_final got %b exp 111111", {at_threshold[1], ovf[1], hold_count[7:4]}); end
  endtask
  task automatic test_down();
    int k = 0;
    lv_in = 2'b01;
    clear = 2'b01;
    cyc();
    clear = 2'b00;
    mode = 4'b1001;
    n_chk++;
    if ({ovf[0], hold_count[3:0]} !== 5'b0_0000) begin n_fail++; $display("FAIL down_clear got %b exp 00000", {ovf[0], hold_count[3:0]}); end
    while (cnt_m[0] != 2 && k < 40) begin cyc(); k++; end
    n_chk++;
    if (k >= 40) begin n_fail++; $display("FAIL down_reach2 timeout got %0d exp 2", hold_count[3:0]); end
    mode = 4'b1011;
    for (int j = 0; j < 16; j++) begin
      cyc();
      n_chk++;
      if (st !== exp_st()) begin n_fail++; $display("FAIL down cyc %0d got %b exp %b", j, st, exp_st()); end
    end
    n_chk++;
    if ({ovf[0], hold_count[3:0]} !== 5'b1_0000) begin n_fail++; $display("FAIL down_final got %b exp 10000", {ovf[0], hold_count[3:0]}); end
  endtask
  task automatic test_clear_tick();
    int k = 0;
    mode = 4'b1001;
    for (int j = 0; j < 8; j++) cyc();
    while (e % 4 != 3 && k < 8) begin cyc(); k++; end
    n_chk++;
    if (hold_count[3:0] === 4'd0 || ovf[0] !== 1'b1 || tick !== 1'b1) begin n_fail++; $display("FAIL clear_pre got cnt %0d ovf %b tick %b exp cnt>0 ovf 1 tick 1", hold_count[3:0], ovf[0], tick); end
    clear = 2'b01;
    cyc();
    clear = 2'b00;
    n_chk++;
    if ({ovf, hold_count} !== 10'b10_1111_0000) begin n_fail++; $display("FAIL clear_tick got %b exp %b", {ovf, hold_count}, 10'b10_1111_0000); end
    n_chk++;
    if (st !== exp_st()) begin n_fail++; $display("FAIL clear_model got %b exp %b", st, exp_st()); end
  endtask
  task automatic test_sync_pulse();
    lv_in = 2'b00;
    clear = 2'b01;
    cyc();
    clear = 2'b00;
    for (int j = 0; j < 4; j++) cyc();
    while (e % 4 != 2) cyc();
    lv_in = 2'b01;
    cyc();
    lv_in = 2'b00;
    for (int j = 0; j < 8; j++) cyc();
    n_chk++;
    if (hold_count[3:0] !== 4'd0) begin n_fail++; $display("FAIL pulse_short got %0d exp 0", hold_count[3:0]); end
    while (e % 4 != 1) cyc();
    lv_in = 2'b01;
    for (int j = 0; j < 3; j++) cyc();
    lv_in = 2'b00;
    for (int j = 0; j < 8; j++) cyc();
    n_chk++;
    if (hold_count[3:0] !== 4'd1) begin n_fail++; $display("FAIL pulse_long got %0d exp 1", hold_count[3:0]); end
    n_chk++;
    if (st !== exp_st()) begin n_fail++; $display("FAIL pulse_model got %b exp %b", st, exp_st()); end
  endtask
  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      lv_in = 2'($urandom);
      if ($urandom_range(15) == 0) mode = 4'($urandom);
      if ($urandom_range(31) == 0) threshold = 4'($urandom);
      clear = {$urandom_range(9) == 0, $urandom_range(9) == 0};
      if (k == 200) begin
        #2 reset = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if (st !== exp_st()) begin n_fail++; $display("FAIL async_reset got %b exp %b", st, exp_st()); end
        for (int j = 0; j < 3; j++) cyc();
        reset = 1'b1;
      end
      cyc();
      n_chk++;
      if (st !== exp_st()) begin n_fail++; $display("FAIL random cyc %0d got %b exp %b", k, st, exp_st()); end
    end
  endtask
  initial begin
    test_reset();
    test_idle();
    test_wrap();
    test_sat();
    test_down();
    test_clear_tick();
    test_sync_pulse();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
